absdiff_serial: RTL
===================

// Module: absdiff_serial
//
// PURPOSE
// - Bit-serial absolute-difference unit; sequential counterpart to the absdiff
//   datapath's combinational 1-bit greater-than comparator chain.
// - Drives operand bit pairs MSB-first through the din/dout/gt comparator
//   recurrence, one bit per cycle, to find which operand is larger.
// - Then subtracts smaller from larger LSB-first with a 1-bit borrow.
// - Val/rdy on both sides; one transaction in flight.
//
// PARAMETERS
// - nbits  8  operand/result width; legal range >= 2
//
// PORTS
// - clk       in   1      clock; all state updates on rising edge
// - rst       in   1      synchronous, active-high reset
// - in_val    in   1      operands valid
// - in_rdy    out  1      unit can accept operands (IDLE only)
// - in_a      in   nbits  operand A (unsigned)
// - in_b      in   nbits  operand B (unsigned)
// - out_val   out  1      result valid
// - out_rdy   in   1      consumer accepts result
// - out_diff  out  nbits  |A-B|
// - out_gt    out  1      1 iff A > B
// - out_eq    out  1      1 iff A == B
//
// BEHAVIOUR
// - States: IDLE -> CMP -> SUB -> DONE -> IDLE. Reset forces IDLE, clears all
//   registers. in_rdy=0 while rst=1; out_val/out_diff/out_gt/out_eq = 0 after reset.
// - IDLE: in_rdy=1. On in_val&&in_rdy, latch A, B; set bit index i=nbits-1;
//   clear done/gt; go to CMP.
// - CMP: one bit per cycle, MSB-first, using the comparator recurrence:
//   - done' = done | (a[i]^b[i])
//   - gt'   = gt | (~done & a[i] & ~b[i])
//   - After bit 0 is evaluated, go to SUB.
// - SUB: nbits cycles, LSB-first, computing L - S with a 1-bit borrow register.
//   - L = gt ? A : B; S = the other operand.
//   - The borrow register clears on entry to SUB.
//   - Each result bit shifts into out_diff from the MSB end.
//   - Final borrow is always 0 (L >= S).
// - DONE: out_val=1. out_diff/out_gt/out_eq are held stable until out_val&&out_rdy.
//   - out_eq = ~done. out_gt = gt.
//   - On handshake, go to IDLE; in_rdy goes high the next cycle. No accept in DONE.
// - Latency (default build), handshake at edge k:
//   - CMP occupies cycles k+1..k+nbits.
//   - SUB occupies cycles k+nbits+1..k+2*nbits.
//   - out_val rises at cycle k+2*nbits+1.
// - Equal operands: out_diff=0, out_gt=0, out_eq=1.
// - out_rdy held high in DONE -> exactly one result cycle.
// - out_rdy low -> result held indefinitely; inputs ignored.
// - rst asserted in any state:
//   - Transaction is discarded; no out_val is ever produced for it.
//   - IDLE on the next cycle.
// - Changes on in_a/in_b after the accept edge have no effect.
//
// CONFIGURATION
// - ABSDIFF_SERIAL_EARLY_EXIT_EN
//   - Defined: CMP leaves for SUB on the cycle the first differing bit sets
//     done, without scanning the remaining bits.
//   - If the first difference is at bit j, CMP takes nbits-j cycles.
//   - Equal operands still take nbits CMP cycles.
//   - Results are identical to the undefined build; only latency shrinks.
//   - Not defined: fixed nbits CMP cycles.
//
// TESTING
// - Reset: rst=1 for 2 cycles -> in_rdy=0, out_val=0, out_diff=0; after
//   release, in_rdy=1.
// - A=8'd200, B=8'd55 -> out_diff=145, out_gt=1, out_eq=0.
//   out_val at k+17 (default build); at k+10 with EARLY_EXIT_EN (diff at bit 7).
// - A=8'd3, B=8'd250 -> out_diff=247, out_gt=0, out_eq=0.
//   A=B=8'hA5 -> out_diff=0, out_gt=0, out_eq=1.
// - Backpressure: out_rdy=0 for 5 cycles in DONE -> outputs stable, in_rdy=0
//   with in_val=1; out_rdy=1 -> IDLE, next op accepted a cycle later.
// - Reset mid-CMP and mid-SUB -> no out_val; next op A=0, B=8'hFF ->
//   out_diff=255, out_gt=0.
// - Back-to-back random ops (>=200, in_val/out_rdy randomly toggled) ->
//   each result matches a golden |A-B| model, in order.

Source files
------------

// File: rtl/absdiff_serial_if.sv
// absdiff_serial_if: handshake/data bundle for the bit-serial absolute-difference unit.
//   in_val/in_rdy/in_a/in_b       : operand request channel
//   out_val/out_rdy/out_diff/
//   out_gt/out_eq                 : result channel
// master: the client (drives operands, accepts results); slave: the unit.
interface absdiff_serial_if #(
    parameter int unsigned nbits = 8
);
    logic             in_val;
    logic             in_rdy;
    logic [nbits-1:0] in_a;
    logic [nbits-1:0] in_b;
    logic             out_val;
    logic             out_rdy;
    logic [nbits-1:0] out_diff;
    logic             out_gt;
    logic             out_eq;

    modport master (
        output in_val, in_a, in_b, out_rdy,
        input  in_rdy, out_val, out_diff, out_gt, out_eq
    );

    modport slave (
        input  in_val, in_a, in_b, out_rdy,
        output in_rdy, out_val, out_diff, out_gt, out_eq
    );
endinterface

// File: rtl/absdiff_serial.sv
// absdiff_serial: bit-serial |A-B| unit.
//   Compares A and B MSB-first one bit per cycle (comparator recurrence on
//   done/gt), then subtracts the smaller from the larger LSB-first with a
//   1-bit borrow. One transaction in flight, val/rdy on both sides.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - absdiff_serial_if.slave (in_val/in_rdy/in_a/in_b,
//          out_val/out_rdy/out_diff/out_gt/out_eq)
// Build option:
//   ABSDIFF_SERIAL_EARLY_EXIT_EN - leave the compare phase as soon as the
//   first differing bit is seen (results unchanged, latency shrinks).
module absdiff_serial #(
    parameter int unsigned nbits = 8
) (
    input logic            clk,
    input logic            rst,
    absdiff_serial_if.slave bus
);
    localparam int unsigned IW = $clog2(nbits);

    typedef enum logic [1:0] {IDLE, CMP, SUB, DONE} state_t;

    state_t           state;
    logic [nbits-1:0] a;
    logic [nbits-1:0] b;
    logic [IW-1:0]    idx;
    logic             done;
    logic             gt;
    logic             borrow;
    logic             rdy;
    logic             val;
    logic [nbits-1:0] diff;
    logic             gt_o;
    logic             eq_o;

    logic a_bit, b_bit;
    logic done_n, gt_n, leave_cmp;
    logic l_bit, s_bit, sub_bit, borrow_n;

    always_comb begin
        a_bit  = a[idx];
        b_bit  = b[idx];
        done_n = done | (a_bit ^ b_bit);
        gt_n   = gt | (~done & a_bit & ~b_bit);
`ifdef ABSDIFF_SERIAL_EARLY_EXIT_EN
        leave_cmp = (idx == '0) || done_n;
`else
        leave_cmp = (idx == '0);
`endif
        // gt is final once SUB starts, so it selects the larger operand.
        l_bit    = gt ? a_bit : b_bit;
        s_bit    = gt ? b_bit : a_bit;
        sub_bit  = l_bit ^ s_bit ^ borrow;
        borrow_n = (~l_bit & s_bit) | (~(l_bit ^ s_bit) & borrow);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a      <= '0;
            b      <= '0;
            idx    <= '0;
            done   <= 1'b0;
            gt     <= 1'b0;
            borrow <= 1'b0;
            rdy    <= 1'b0;
            val    <= 1'b0;
            diff   <= '0;
            gt_o   <= 1'b0;
            eq_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rdy <= 1'b1;
                    if (bus.in_val && rdy) begin
                        a     <= bus.in_a;
                        b     <= bus.in_b;
                        idx   <= IW'(nbits - 1);
                        done  <= 1'b0;
                        gt    <= 1'b0;
                        rdy   <= 1'b0;
                        state <= CMP;
                    end
                end
                CMP: begin
                    done <= done_n;
                    gt   <= gt_n;
                    if (leave_cmp) begin
                        idx    <= '0;
                        borrow <= 1'b0;
                        state  <= SUB;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                SUB: begin
                    // LSB-first result bits enter at the MSB end; after nbits
                    // shifts bit 0 of the result sits at bit 0.
                    diff   <= {sub_bit, diff[nbits-1:1]};
                    borrow <= borrow_n;
                    if (idx == IW'(nbits - 1)) begin
                        val   <= 1'b1;
                        gt_o  <= gt;
                        eq_o  <= ~done;
                        state <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_rdy) begin
                        val   <= 1'b0;
                        rdy   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_rdy   = rdy;
    assign bus.out_val  = val;
    assign bus.out_diff = diff;
    assign bus.out_gt   = gt_o;
    assign bus.out_eq   = eq_o;
endmodule
